// File: rtl/led_pwm_chaser.sv
// N_LED PWM chaser: shared period counter, wrap-latched mode/duty, off/blink/chase/bounce.
// Optional LED_BREATHE_EN: mode 01 ramps an internal triangle duty instead of using duty.
module led_pwm_chaser #(
  parameter int unsigned N_LED        = 4,
  parameter int unsigned CNT_W        = 23,
  parameter int unsigned PERIOD       = 5_000_000,
  parameter int unsigned POS_W        = 2,
  parameter int unsigned BREATHE_STEP = 50_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] duty,
  output logic [N_LED-1:0] LED_out,
  output logic [POS_W-1:0] pos,
  output logic             period_tick
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_duty_q;
  mode_e            r_mode_q;
  dir_e             r_dir;

  mode_e            w_mode_in;
  logic             w_wrap;
  logic             w_mode_chg;
  logic             w_on;
  logic [CNT_W:0]   w_duty_eff;
  logic [POS_W-1:0] w_pos_inc;
  logic [POS_W-1:0] w_pos_dec;
  logic [POS_W-1:0] w_pos_nxt;
  dir_e             w_dir_nxt;
  logic [N_LED-1:0] w_led;

  assign w_mode_in  = mode_e'(mode);
  assign w_wrap     = en && (r_cnt == CNT_LAST);
  assign w_mode_chg = (w_mode_in != r_mode_q);
  assign w_on       = ({1'b0, r_cnt} < w_duty_eff);
  assign w_pos_inc  = pos + 1'b1;
  assign w_pos_dec  = pos - 1'b1;

`ifdef LED_BREATHE_EN
  localparam logic [CNT_W+1:0] B_STEP = (CNT_W + 2)'(BREATHE_STEP);
  localparam logic [CNT_W+1:0] B_TOP  = (CNT_W + 2)'(PERIOD);
  localparam logic [CNT_W:0]   B_TOPN = (CNT_W + 1)'(PERIOD);

  logic [CNT_W:0]   r_bduty;
  dir_e             r_bdir;
  logic [CNT_W+1:0] w_bsum;

  assign w_bsum     = {1'b0, r_bduty} + B_STEP;
  assign w_duty_eff = (r_mode_q == MODE_BLINK) ? r_bduty : {1'b0, r_duty_q};

  // Triangle ramp advances once per wrap; any mode change restarts it from zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bduty <= '0;
      r_bdir  <= DIR_UP;
    end else if (w_wrap) begin
      if (w_mode_chg) begin
        r_bduty <= '0;
        r_bdir  <= DIR_UP;
      end else if (r_mode_q == MODE_BLINK) begin
        if (r_bdir == DIR_UP) begin
          if (w_bsum >= B_TOP) begin
            r_bduty <= B_TOPN;
            r_bdir  <= DIR_DOWN;
          end else begin
            r_bduty <= w_bsum[CNT_W:0];
          end
        end else begin
          if ({1'b0, r_bduty} <= B_STEP) begin
            r_bduty <= '0;
            r_bdir  <= DIR_UP;
          end else begin
            r_bduty <= r_bduty - B_STEP[CNT_W:0];
          end
        end
      end
    end
  end
`else
  assign w_duty_eff = {1'b0, r_duty_q};
`endif

  // Bounce flips dir on the same step that lands on an endpoint, so endpoints are not repeated.
  always_comb begin
    w_pos_nxt = pos;
    w_dir_nxt = r_dir;
    if (w_mode_chg) begin
      w_pos_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (N_LED > 1) begin
      case (r_mode_q)
        MODE_CHASE: w_pos_nxt = (pos >= POS_LAST) ? '0 : w_pos_inc;
        MODE_BOUNCE: begin
          if (r_dir == DIR_UP) begin
            if (pos >= POS_LAST) begin
              w_pos_nxt = w_pos_dec;
              w_dir_nxt = DIR_DOWN;
            end else begin
              w_pos_nxt = w_pos_inc;
              w_dir_nxt = (w_pos_inc == POS_LAST) ? DIR_DOWN : DIR_UP;
            end
          end else begin
            if (pos == '0) begin
              w_pos_nxt = w_pos_inc;
              w_dir_nxt = DIR_UP;
            end else begin
              w_pos_nxt = w_pos_dec;
              w_dir_nxt = (w_pos_dec == '0) ? DIR_UP : DIR_DOWN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_led = '0;
    case (r_mode_q)
      MODE_BLINK: w_led = {N_LED{w_on}};
      MODE_CHASE, MODE_BOUNCE: begin
        for (int unsigned i = 0; i < N_LED; i++) begin
          if (pos == POS_W'(i)) w_led[i] = w_on;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt       <= '0;
      r_duty_q    <= '0;
      r_mode_q    <= MODE_OFF;
      r_dir       <= DIR_UP;
      pos         <= '0;
      LED_out     <= '0;
      period_tick <= 1'b0;
    end else if (!en) begin
      r_cnt       <= '0;
      LED_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      r_cnt       <= w_wrap ? '0 : r_cnt + 1'b1;
      LED_out     <= w_led;
      period_tick <= w_wrap;
      if (w_wrap) begin
        r_mode_q <= w_mode_in;
        r_duty_q <= duty;
        pos      <= w_pos_nxt;
        r_dir    <= w_dir_nxt;
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_chaser.sv
// Directed bench for led_pwm_chaser with PERIOD=10, CNT_W=4, N_LED=4, POS_W=2.
module tb_led_pwm_chaser;

  logic       CLK;
  logic       RST;
  logic       en;
  logic [1:0] mode;
  logic [3:0] duty;
  logic [3:0] LED_out;
  logic [1:0] pos;
  logic       period_tick;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned chase_seq[5]  = '{0, 1, 2, 3, 0};
  int unsigned bounce_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int unsigned breathe_seq[8] = '{0, 4, 8, 10, 6, 2, 0, 4};

  led_pwm_chaser #(
    .N_LED(4),
    .CNT_W(4),
    .PERIOD(10),
    .POS_W(2),
    .BREATHE_STEP(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .en(en),
    .mode(mode),
    .duty(duty),
    .LED_out(LED_out),
    .pos(pos),
    .period_tick(period_tick)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Steps until period_tick rises (bounded) and checks the edge count.
  task automatic wait_wrap(input string tag, input int unsigned exp_cycles);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (!period_tick && n < 3 * 10);
    check(tag, n, exp_cycles);
  endtask

  initial begin
    logic [3:0] exp_led;
    int unsigned ones;

    RST = 1'b1; en = 1'b0; mode = 2'b00; duty = 4'd0;
    tick();
    tick();
    check("rst_led", LED_out, 0);
    check("rst_pos", pos, 0);
    check("rst_tick", period_tick, 0);

    RST = 1'b0; en = 1'b1; mode = 2'b01; duty = 4'd3;
`ifdef LED_BREATHE_EN
    duty = 4'd7;
`endif
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("first_period_led", LED_out, 0);
      check("first_period_tick", period_tick, (k == 10) ? 1 : 0);
    end

`ifdef LED_BREATHE_EN
    foreach (breathe_seq[i]) begin
      ones = 0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (LED_out == 4'hF) ones++;
        if (k == 5) duty = 4'($urandom_range(0, 15));
      end
      check("breathe_duty", ones, breathe_seq[i]);
      check("breathe_tick", period_tick, 1);
    end
`else
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("blink_led", LED_out, (k <= 3) ? 32'hF : 32'h0);
      check("blink_tick", period_tick, (k == 10) ? 1 : 0);
    end
`endif

    mode = 2'b10; duty = 4'd10;
    wait_wrap("chase_enter", 10);
    foreach (chase_seq[i]) begin
      check("chase_pos", pos, chase_seq[i]);
      exp_led = 4'b0001 << chase_seq[i];
      for (int k = 1; k <= 10; k++) begin
        tick();
        check("chase_led", LED_out, exp_led);
        check("chase_tick", period_tick, (k == 10) ? 1 : 0);
      end
    end

    mode = 2'b11;
    wait_wrap("bounce_enter", 10);
    foreach (bounce_seq[i]) begin
      check("bounce_pos", pos, bounce_seq[i]);
      exp_led = 4'b0001 << bounce_seq[i];
      for (int k = 1; k <= 10; k++) begin
        tick();
        check("bounce_led", LED_out, exp_led);
      end
    end
    check("bounce_pos_end", pos, 2);

    mode = 2'b10; duty = 4'd0;
    wait_wrap("duty0_enter", 10);
    check("duty0_pos", pos, 0);
    duty = 4'd15;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("duty0_led", LED_out, 0);
    end
    check("duty15_pos", pos, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("duty15_led", LED_out, 4'b0010);
    end
    check("pre_en_pos", pos, 2);

    repeat (4) tick();
    check("pre_en_led", LED_out, 4'b0100);
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("en_off_led", LED_out, 0);
      check("en_off_pos", pos, 2);
      check("en_off_tick", period_tick, 0);
    end
    en = 1'b1;
    wait_wrap("en_resume_wrap", 10);
    check("en_resume_pos", pos, 3);

    mode = 2'b10;
    wait_wrap("to_pos2", 10);
    check("mid_pos", pos, 0);
    wait_wrap("to_pos1", 10);
    wait_wrap("to_pos2b", 10);
    check("pre_rst_pos", pos, 2);
    repeat (3) tick();
    RST = 1'b1;
    tick();
    check("midrst_pos", pos, 0);
    check("midrst_led", LED_out, 0);
    check("midrst_tick", period_tick, 0);
    RST = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("post_rst_led", LED_out, 0);
      check("post_rst_tick", period_tick, (k == 10) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_chaser.md
Name: led_pwm_chaser

Overview:
- Parametrised successor to the single-LED fixed-duty blinker.
- Drives N_LED outputs from one shared period counter.
- Supports a runtime-programmable PWM duty and four display modes: off, all-blink, chase (flowing light) and bounce (ping-pong).
- Sits between board-level LED pins and a control/register block that supplies mode and duty.

Parameters:
- N_LED, 4: number of LED outputs; legal range 1..16.
- CNT_W, 23: width of the period counter and of the duty input; must hold PERIOD-1.
- PERIOD, 5_000_000: cycles per period (100 ms at 50 MHz); must be at least 2.
- POS_W, 2: width of the pos output; must be at least max(1, clog2(N_LED)).
- BREATHE_STEP, 50_000: duty increment per period; used only when LED_BREATHE_EN is defined.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  synchronous reset, active-high.
- en  in  1  run enable.
- mode  in  2  display mode: 00 off, 01 all-blink, 10 chase, 11 bounce.
- duty  in  CNT_W  PWM on-time in cycles per period.
- LED_out  out  N_LED  LED drive, active-high, registered.
- pos  out  POS_W  current chase/bounce position, registered.
- period_tick  out  1  one-cycle pulse on each period wrap, registered.

Behaviour:
- Reset: synchronous, active-high. RST=1 at an edge sets cnt=0, pos=0, dir=up, mode_q=00, duty_q=0, LED_out=0, period_tick=0. RST has priority over all other inputs.
- Reset mid-operation: on the next edge after RST=1, all state returns to these values.
- Counter: while en=1, cnt increments by 1 per cycle. When cnt==PERIOD-1 it wraps to 0, so the period is exactly PERIOD cycles.
- Wrap edge, all in the same edge as cnt returns to 0:
  - mode_q <= mode;
  - duty_q <= duty;
  - pos and dir update (rules below);
  - period_tick <= 1. period_tick is 0 on every other cycle.
- Mode and duty changes take effect only at a wrap; there are no mid-period glitches. Consequence: the first PERIOD cycles after reset display mode 00 (all off).
- Mode change: if the mode being latched differs from the current mode_q, pos <= 0 and dir <= up instead of advancing.
- Chase (mode_q=10): pos advances 0,1,…,N_LED-1,0,… (wrap-around).
- Bounce (mode_q=11):
  - pos moves up to N_LED-1, then down to 0, then up again.
  - The endpoint is not repeated, e.g. 0,1,2,3,2,1,0,1 for N_LED=4.
  - dir flips in the same edge pos reaches an end.
- N_LED=1: pos stays 0 in both chase and bounce.
- Other modes: pos holds its value.
- PWM: on = (cnt < duty_q).
  - duty_q=0: always off.
  - duty_q>=PERIOD: always on.
- LED_out <= function of the current cnt, mode_q, duty_q and pos (one cycle of latency after cnt):
  - 00: all 0;
  - 01: all bits = on;
  - 10 or 11: bit[pos] = on, all other bits 0.
- en=0:
  - cnt <= 0, LED_out <= 0, period_tick <= 0;
  - pos, dir, mode_q and duty_q hold.
- en rising: counting resumes from cnt=0. The first wrap occurs PERIOD cycles later.

Optional Feature:
- Macro: LED_BREATHE_EN.
- Defined: mode 01 ignores duty_q and uses an internal breathing duty bduty.
  - Reset value: bduty=0, direction up.
  - At each wrap in mode 01: bduty += BREATHE_STEP. Once bduty >= PERIOD, clamp to PERIOD and reverse direction.
  - Downward: bduty -= BREATHE_STEP, clamping at 0 and reversing.
  - Result is a triangle ramp.
  - Entering mode 01 from another mode resets bduty to 0, direction up.
  - Modes 10/11 still use duty_q.
- Not defined: no bduty logic exists, BREATHE_STEP is unused, and mode 01 uses duty_q.

Test Plan:
1. Bench parameters for all scenarios: PERIOD=10, CNT_W=4, N_LED=4, POS_W=2, CLK running.
2. Reset, then en=1, mode=01, duty=3 -> LED_out=0000 for the first 10 cycles; period_tick pulses 10 cycles after release; then each 10-cycle window shows LED_out=1111 for 3 cycles and 0000 for 7.
3. mode=10, duty=10 -> one LED lit per period; pos sequence 0,1,2,3,0, LED_out 0001,0010,0100,1000,0001, changing on period_tick.
4. mode=11, duty=10 -> pos sequence 0,1,2,3,2,1,0,1 over eight periods.
5. Edge and interruption cases:
   - duty=0 -> LED_out stays 0.
   - duty=15 -> LED_out continuously lit.
   - en=0 for 5 cycles mid-period -> LED_out=0; pos held; next wrap occurs 10 cycles after en returns to 1.
   - RST=1 mid-chase at pos=2 -> next edge gives pos=0, LED_out=0, period_tick=0.
6. With LED_BREATHE_EN defined, BREATHE_STEP=4, mode=01 -> duty observed per period 0,4,8,10,6,2,0,4; duty input changes have no effect.
